// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done and the result.
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   d;

    modport master (
        output start, x, y, bin,
        input  busy, done, d
    );

    modport slave (
        input  start, x, y, bin,
        output busy, done, d
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: d = x - y - bin, one bit per clock through
// a single registered full-subtractor cell, sequenced by an IDLE/SUB/DONE FSM.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_ripple_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    // Only the upper WIDTH-1 difference bits survive to the result, so the
    // bit that would fall off the LSB end of the shift register is not stored.
    logic [WIDTH-2:0] ds;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   d_reg;

    logic             di;
    logic             bo;
    logic [WIDTH-1:0] ds_shift;
    logic             last;

    always_comb begin
        di       = xs[0] ^ ys[0] ^ br;
        bo       = (~xs[0] & ys[0]) | (~xs[0] & br) | (ys[0] & br);
        ds_shift = {di, ds};
        last     = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SUB;
            SUB:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.d    = d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs    <= '0;
            ys    <= '0;
            ds    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            d_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xs  <= bus.x;
                        ys  <= bus.y;
                        br  <= bus.bin;
                        cnt <= '0;
                        ds  <= '0;
                    end
                end
                SUB: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    br  <= bo;
                    ds  <= ds_shift[WIDTH-1:1];
                    // Hold the counter on the final bit so it never wraps.
                    cnt <= last ? cnt : cnt + CNT_W'(1);
                    if (last) begin
                        d_reg <= {bo, ds_shift};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse and checks d is held otherwise.
module tb_serial_ripple_subtractor;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;

    logic [WIDTH:0] sb[$];
    int             done_times[$];
    logic [WIDTH:0] held_d = '0;
    logic [WIDTH:0] mon_exp;

    serial_ripple_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: (WIDTH+1)-bit two's complement of x - y - bin.
    function automatic logic [WIDTH:0] ref_sub(input int a, input int b, input int c);
        int r;
        r = a - b - c;
        if (r < 0) r += (1 << (WIDTH + 1));
        return r[WIDTH:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held_d = '0;
        end else if (bus.done) begin
            done_cnt++;
            done_times.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                check("result", int'(bus.d), int'(mon_exp));
                held_d = mon_exp;
            end
        end else begin
            check("d_hold", int'(bus.d), int'(held_d));
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input bit timing);
        int lat    = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        bit fin    = 1'b0;
        @(negedge clk);
        bus.x     = a;
        bus.y     = b;
        bus.bin   = c;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sub(int'(a), int'(b), int'(c)));
        #1;
        bus.start = 1'b0;
        bus.x     = WIDTH'($urandom);
        bus.y     = WIDTH'($urandom);
        bus.bin   = 1'($urandom);
        if (bus.busy) busy_n++;
        if (timing) check("busy_rise", int'(bus.busy), 1);
        for (int i = 1; i <= 20 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (bus.done && !seen) begin
                seen = 1'b1;
                lat  = i;
            end
            if (bus.busy) busy_n++;
            else fin = 1'b1;
        end
        if (!fin) check("timeout_op", 0, 1);
        if (timing) begin
            check("latency", lat, WIDTH);
            check("busy_cycles", busy_n, WIDTH + 1);
            check("done_fall", int'(bus.done), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int t0;
        int w;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_d", int'(bus.d), 0);
        #2 rst_n = 1'b1;

        // Directed values, including boundaries.
        run_op(4'd6, 4'd5, 1'b0, 1'b1);
        run_op(4'd5, 4'd6, 1'b0, 1'b1);
        run_op(4'd8, 4'd8, 1'b1, 1'b1);
        run_op(4'd0, 4'd15, 1'b1, 1'b1);
        run_op(4'd15, 4'd0, 1'b0, 1'b1);
        run_op(4'd0, 4'd0, 1'b0, 1'b1);

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_op(WIDTH'(a), WIDTH'(b), 1'(c), 1'b0);

        // Randomized operands with random idle gaps.
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
        end

        // start during SUB and DONE must be ignored.
        c0 = done_cnt;
        @(negedge clk);
        bus.x = 4'd9; bus.y = 4'd3; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sub(9, 3, 0));
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.x = 4'd1; bus.y = 4'd2; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_in_sub", int'(bus.busy), 1);
        w = 0;
        @(negedge clk);
        while (!bus.done && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!bus.done) check("timeout_ignore", 0, 1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("idle_after_done", int'(bus.busy), 0);
        repeat (8) @(negedge clk);
        check("no_requeue_busy", int'(bus.busy), 0);
        check("single_done", done_cnt - c0, 1);

        // start held high: back-to-back operations.
        t0 = done_times.size();
        for (int k = 0; k < 6; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.busy && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (bus.busy) check("timeout_b2b", 0, 1);
            if (k % 2 == 0) begin
                bus.x = 4'd6; bus.y = 4'd5;
            end else begin
                bus.x = 4'd5; bus.y = 4'd6;
            end
            bus.bin   = 1'b0;
            bus.start = 1'b1;
            @(posedge clk);
            sb.push_back((k % 2 == 0) ? ref_sub(6, 5, 0) : ref_sub(5, 6, 0));
        end
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_count", done_times.size() - t0, 6);
        for (int i = t0 + 1; i < done_times.size(); i++)
            check("done_spacing", done_times[i] - done_times[i-1], WIDTH + 2);

        // Asynchronous reset in the second SUB cycle aborts the operation.
        @(negedge clk);
        bus.x = 4'd12; bus.y = 4'd3; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sub(12, 3, 0));
        #1 bus.start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_d", int'(bus.d), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(4'd12, 4'd3, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial ripple-borrow subtractor: computes `x - y - bin` one bit per clock through a single registered full-subtractor cell. It is the inverse-operation, sequential counterpart of the team's combinational ripple-carry adder. It serves area-constrained datapaths that already own a clock and can tolerate WIDTH-cycle latency. A start/busy/done handshake sequences it; the result, including borrow-out, is held until the next operation completes.

## Interface
- `WIDTH`, 4, operand width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `x`  input  WIDTH  minuend; sampled on the accepting edge only.
- `y`  input  WIDTH  subtrahend; sampled on the accepting edge only.
- `bin`  input  1  borrow-in; sampled on the accepting edge only.
- `busy`  output  1  high whenever state is not IDLE.
- `done`  output  1  one-cycle pulse; `d` is valid in that cycle.
- `d`  output  WIDTH+1  result. `d[WIDTH-1:0]` is the difference and `d[WIDTH]` is borrow-out.

## Operation
- State machine states: IDLE, SUB, DONE.
- **IDLE**
  - On an edge with `start=1`: load `xs<=x`, `ys<=y`, `br<=bin`, `cnt<=0`, clear the difference shift register `ds`, then go to SUB.
  - If `start=0`: stay in IDLE.
- **SUB**, every edge:
  - Compute `di = xs[0]^ys[0]^br`.
  - Compute `bo = (~xs[0]&ys[0]) | (~xs[0]&br) | (ys[0]&br)`.
  - Update `ds <= {di, ds[WIDTH-1:1]}` (LSB first, shifted in at the MSB end), `br <= bo`.
  - Shift `xs` and `ys` right by 1; `cnt <= cnt+1`.
  - When `cnt == WIDTH-1` on this edge: load `d <= {bo, di, ds[WIDTH-1:1]}` and go to DONE.
- **DONE**: `done=1` for exactly one cycle; next edge goes to IDLE unconditionally.
- Arithmetic rules:
  - `d[WIDTH-1:0] = (x - y - bin) mod 2^WIDTH`.
  - `d[WIDTH] = 1` iff `x < y + bin`, with both operands treated as unsigned.
  - Equivalently, `{d[WIDTH], d[WIDTH-1:0]}` is the (WIDTH+1)-bit two's-complement of `x - y - bin`.
- `d` changes only on the SUB→DONE edge. It holds its value through IDLE and through the following operation until that operation's DONE.
- `start` in SUB or DONE is ignored, with no queuing. `x`, `y`, `bin` may change freely after the accepting edge.
- `cnt` width is `$clog2(WIDTH)`; it never wraps in normal operation.

## Timing
- Reset (`rst_n=0`, asynchronous, effective immediately):
  - state=IDLE, `busy=0`, `done=0`, `d=0`.
  - Internal registers `xs`, `ys`, `ds`, `br`, `cnt` are cleared to 0.
- Reset mid-operation aborts the operation. `d` reads 0 after reset, not the prior result. The first edge after `rst_n` rises may accept `start`.
- Let the accepting edge be E0:
  - `busy` rises after E0.
  - SUB occupies edges E1..E(WIDTH).
  - `done=1` and the new `d` are visible after E(WIDTH).
  - IDLE is re-entered after E(WIDTH+1), where `busy` and `done` fall together.
- Latency from the accepting edge to `done` is WIDTH cycles.
- With `start` held high, throughput is one operation per WIDTH+2 cycles. The next accepting edge is E(WIDTH+2).
- `busy` and `done` are registered-state decodes, glitch-free, with no combinational path from inputs.

## Test plan
All scenarios use WIDTH=4.
- `x=6, y=5, bin=0`, `start` pulsed one cycle → `done` exactly 4 cycles after the accepting edge; `d=5'b0_0001`; `busy` high for 5 cycles.
- `x=5, y=6, bin=0` → `d=5'h1F` (borrow=1, diff=4'hF). `x=8, y=8, bin=1` → `d=5'h1F`. `x=0, y=15, bin=1` → `d=5'h10`.
- Boundaries: `x=15, y=0, bin=0` → `d=5'h0F`; `x=0, y=0, bin=0` → `d=5'h00`. Exhaustive sweep of all 512 (`x`, `y`, `bin`) combinations matches `{1'b0,x}-{1'b0,y}-bin` mod 32.
- Launch `x=9, y=3`, then change the inputs to `x=1, y=2` and pulse `start` during SUB and during DONE → both ignored; `d=5'h06`; exactly one `done` pulse.
- `start` held high with operands alternating (6,5) and (5,6) → `done` pulses spaced exactly 6 cycles apart; results alternate `5'h01`, `5'h1F`; `d` is held between pulses.
- Assert `rst_n=0` asynchronously in the 2nd SUB cycle of `x=12, y=3` → immediately `busy=0`, `done=0`, `d=0`. After release, `x=12, y=3` completes with `d=5'h09` in 4 cycles.
